// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle control path: opcodes, ALU op,
// datapath mux selects and the main-control state set.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main-control FSM (master) and the datapath (slave).
interface mc_control_fsm_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            mem_ready;
    logic            mem_req;
    logic            mem_write;
    logic            iord;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [1:0]      pc_src;
    logic            pc_en;
    logic            illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle main control: one registered state, Moore decode of the datapath
// controls, with pc_en and illegal_op qualified combinationally.
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter int OP_W = 6
) (
    input logic              clk,
    input logic              rst,
    mc_control_fsm_if.master bus
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] opcode;
    logic            legal_op;
    logic            pc_write;
    logic            branch;

    assign opcode = bus.opcode;

    always_comb begin
        case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: legal_op = 1'b1;
            default:                                       legal_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low while rst is high, even in the first reset cycle
    // when state_q still holds the aborted instruction's state.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_REG;
        bus.alu_op     = ALUOP_ADD;
        bus.pc_src     = PCSRC_ALU;
        bus.illegal_op = 1'b0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    pc_write      = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b  = SRCB_IMM_SH2;
                    bus.illegal_op = ~legal_op;
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req   = 1'b1;
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALUOP_SUB;
                    bus.pc_src    = PCSRC_ALUOUT;
                    branch        = 1'b1;
                end
                S_ADDIWB: bus.reg_write = 1'b1;
                S_JUMP: begin
                    bus.pc_src = PCSRC_JUMP;
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
        bus.pc_en = pc_write | (branch & bus.zero);
    end

endmodule
